onn_neuron_bank: RTL and testbench



---
 rtl/onn_pkg.sv | 11 +
 rtl/onn_phase_cell.sv | 36 +++
 rtl/onn_neuron_bank.sv | 107 ++++++++++
 tb/tb_onn_neuron_bank.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/onn_pkg.sv
// onn_pkg: shared state type, default sizing and phase helper for the ONN neuron bank.
package onn_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, RUN, STOPPING, READ} state_t;
  localparam int PW = 4;
  localparam int N = 15;
  localparam int HALF = 1 << (PW - 1);
  localparam int PMAX = (1 << PW) - 1;
  function automatic logic [31:0] phase_dist(input logic [31:0] r, input logic [31:0] p, input int w);
    return (r - p) & ((32'd1 << w) - 32'd1);
  endfunction
endpackage

// File: rtl/onn_phase_cell.sv
// onn_phase_cell: one oscillator neuron with its phase offset, load shift stage and phase-nudge coupling.
module onn_phase_cell import onn_pkg::*; #(
  parameter int PHASE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               shift_en,
  input  logic [PHASE_W-1:0] shift_in,
  input  logic               active,
  input  logic               nout_en,
  input  logic               tick,
  input  logic [PHASE_W-1:0] ref_phase,
  input  logic               nin,
  output logic [PHASE_W-1:0] phi,
  output logic               nout
);
  localparam logic [PHASE_W-1:0] H = PHASE_W'(1 << (PHASE_W - 1));
  localparam logic [PHASE_W-1:0] ONE = PHASE_W'(1);
  logic [PHASE_W-1:0] lp;
  logic nin_q, adj_done, nudge;
  assign lp = PHASE_W'(phase_dist(32'(ref_phase), 32'(phi), PHASE_W));
  // only the first non-zero correction in a period counts
  assign nudge = active && nin && !nin_q && !adj_done && lp != '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      phi <= '0;
      nin_q <= 1'b0;
      adj_done <= 1'b0;
      nout <= 1'b0;
    end else begin
      phi <= shift_en ? shift_in : nudge ? (lp < H ? phi + ONE : phi - ONE) : phi;
      nin_q <= nin;
      adj_done <= (tick || !active) ? 1'b0 : adj_done || nudge;
      nout <= nout_en && lp < H;
    end
endmodule

// File: rtl/onn_neuron_bank.sv
// onn_neuron_bank: ROWS x COLS phase-coded oscillator bank with serial load,
// shared period reference, per-neuron coupling and handshaked phase readout.
module onn_neuron_bank import onn_pkg::*; #(
  parameter int ROWS = 3,
  parameter int COLS = 5,
  parameter int PHASE_W = 4,
  localparam int NB = ROWS * COLS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_load,
  input  logic                  cmd_run,
  input  logic                  cmd_stop,
  input  logic                  cmd_read,
  input  logic                  ld_valid,
  input  logic                  ld_data,
  output logic                  ld_ready,
  input  logic [NB-1:0]         nin,
  output logic [NB-1:0]         nout,
  output logic                  full_tick,
  output logic [NB*PHASE_W-1:0] phi_flat,
  output logic                  rd_valid,
  output logic [PHASE_W-1:0]    rd_data,
  output logic                  rd_last,
  input  logic                  rd_ready,
  output logic                  busy
);
  localparam int CW = $clog2(NB + 1);
  localparam logic [PHASE_W-1:0] H = PHASE_W'(1 << (PHASE_W - 1));
  localparam logic [PHASE_W-1:0] PM = '1;
  state_t state;
  logic [PHASE_W-1:0] ref_phase;
  logic [CW-1:0] cnt;
  logic [NB*PHASE_W-1:0] rd_buf, chain;
  logic active, nout_en, shift_en;
  assign active = state == RUN || state == STOPPING;
  assign full_tick = active && ref_phase == PM;
  // nout must already be low on the first IDLE cycle after a stop completes
  assign nout_en = (state == RUN && !(cmd_stop && full_tick)) || (state == STOPPING && !full_tick);
  assign shift_en = state == LOAD && ld_valid;
  assign ld_ready = state == LOAD;
  assign busy = state != IDLE;
  assign rd_data = rd_buf[PHASE_W-1:0];
  assign chain = {phi_flat[(NB-1)*PHASE_W-1:0], ld_data ? H : '0};
  for (genvar i = 0; i < NB; i++) begin : g_cell
    onn_phase_cell #(.PHASE_W(PHASE_W)) u_cell (
      .clk(clk),
      .rst_n(rst_n),
      .shift_en(shift_en),
      .shift_in(chain[i*PHASE_W +: PHASE_W]),
      .active(active),
      .nout_en(nout_en),
      .tick(full_tick),
      .ref_phase(ref_phase),
      .nin(nin[i]),
      .phi(phi_flat[i*PHASE_W +: PHASE_W]),
      .nout(nout[i])
    );
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      ref_phase <= '0;
      cnt <= '0;
      rd_buf <= '0;
      rd_valid <= 1'b0;
      rd_last <= 1'b0;
    end else
      case (state)
        IDLE:
          if (cmd_load) begin
            state <= LOAD;
            cnt <= '0;
          end else if (cmd_read) begin
            state <= READ;
            rd_buf <= phi_flat;
            rd_valid <= 1'b1;
            rd_last <= NB == 1;
            cnt <= '0;
          end else if (cmd_run) begin
            state <= RUN;
            ref_phase <= '0;
          end
        LOAD:
          if (shift_en) begin
            cnt <= cnt == CW'(NB - 1) ? '0 : cnt + CW'(1);
            state <= cnt == CW'(NB - 1) ? IDLE : LOAD;
          end
        RUN: begin
          ref_phase <= ref_phase + PHASE_W'(1);
          if (cmd_stop) state <= full_tick ? IDLE : STOPPING;
        end
        STOPPING: begin
          ref_phase <= ref_phase + PHASE_W'(1);
          if (full_tick) state <= IDLE;
        end
        READ:
          if (rd_ready) begin
            rd_buf <= rd_buf >> PHASE_W;
            cnt <= cnt + CW'(1);
            rd_last <= !rd_last && cnt == CW'(NB - 2);
            rd_valid <= !rd_last;
            state <= rd_last ? IDLE : READ;
          end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_onn_neuron_bank.sv
// tb_onn_neuron_bank: directed and randomized checks of the neuron bank against a phase-arithmetic model.
module tb_onn_neuron_bank;
  import onn_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0;
  logic cmd_load = 1'b0, cmd_run = 1'b0, cmd_stop = 1'b0, cmd_read = 1'b0;
  logic ld_valid = 1'b0, ld_data = 1'b0, ld_ready;
  logic [N-1:0] nin = '0, nout;
  logic full_tick, rd_valid, rd_last, busy;
  logic rd_ready = 1'b0;
  logic [N*PW-1:0] phi_flat;
  logic [PW-1:0] rd_data;
  int n_assert = 0, n_fail = 0;
  int phi_m [N];
  int r = 0;
  logic [N-1:0] exp_nout = '0, nin_prev = '0, done = '0;
  int n_tick, n_hi0, n_hi14;

  onn_neuron_bank #(.ROWS(3), .COLS(5), .PHASE_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_load(cmd_load), .cmd_run(cmd_run), .cmd_stop(cmd_stop),
    .cmd_read(cmd_read), .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
    .nin(nin), .nout(nout), .full_tick(full_tick), .phi_flat(phi_flat), .rd_valid(rd_valid),
    .rd_data(rd_data), .rd_last(rd_last), .rd_ready(rd_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N*PW-1:0] pack();
    logic [N*PW-1:0] v = '0;
    for (int i = 0; i < N; i++) v[i*PW +: PW] = PW'(phi_m[i]);
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) phi_m[i] = 0;
    r = 0;
    exp_nout = '0;
    nin_prev = '0;
    done = '0;
  endtask

  task automatic pulse(input logic l, input logic rd, input logic rn);
    cmd_load = l;
    cmd_read = rd;
    cmd_run = rn;
    @(negedge clk);
    cmd_load = 1'b0;
    cmd_read = 1'b0;
    cmd_run = 1'b0;
  endtask

  // bits[k] is the k-th bit sent; gap < 0 picks random idle cycles between beats
  task automatic load(input logic [N-1:0] bits, input int gap, input logic multi);
    int g;
    pulse(1'b1, multi, multi);
    for (int k = 0; k < N; k++) begin
      g = gap < 0 ? int'($urandom_range(0, 3)) : gap;
      repeat (g) @(negedge clk);
      chk("ld_ready_hi", 64'(ld_ready), 64'(1));
      ld_valid = 1'b1;
      ld_data = bits[k];
      @(negedge clk);
      ld_valid = 1'b0;
    end
    chk("ld_ready_lo", 64'(ld_ready), 64'(0));
    chk("busy_after_load", 64'(busy), 64'(0));
    for (int k = 0; k < N; k++) phi_m[N-1-k] = bits[k] ? HALF : 0;
    chk("phi_after_load", 64'(phi_flat), 64'(pack()));
  endtask

  // mode 0: nin idle, 1: nin[0] edge at ref 3 (plus a second edge at 9 in the first period), 2: random nin
  task automatic run_model(input int cycles, input int mode, input int stop_at, input int stop_after);
    logic [N-1:0] nv, nn;
    logic stopping = 1'b0, fin = 1'b0;
    int d;
    for (int c = 0; c < cycles && !fin; c++) begin
      chk("full_tick", 64'(full_tick), 64'(r == PMAX));
      chk("nout", 64'(nout), 64'(exp_nout));
      chk("phi_run", 64'(phi_flat), 64'(pack()));
      n_tick += int'(full_tick);
      n_hi0 += int'(nout[0]);
      n_hi14 += int'(nout[N-1]);
      nv = mode == 0 ? '0 : mode == 1 ? N'((r == 3 || r == 4 || (c < 16 && r == 9)) ? 1 : 0) : N'($urandom);
      nin = nv;
      cmd_stop = !stopping && c >= stop_after && r == stop_at;
      if (cmd_stop) stopping = 1'b1;
      fin = stopping && r == PMAX;
      for (int i = 0; i < N; i++) begin
        d = (r - phi_m[i]) & PMAX;
        nn[i] = !fin && d < HALF;
        if (nv[i] && !nin_prev[i] && !done[i] && d != 0) begin
          phi_m[i] = (phi_m[i] + (d < HALF ? 1 : -1)) & PMAX;
          done[i] = 1'b1;
        end
      end
      if (r == PMAX) done = '0;
      exp_nout = nn;
      nin_prev = nv;
      r = (r + 1) & PMAX;
      @(negedge clk);
      cmd_stop = 1'b0;
    end
    if (fin) begin
      chk("stop_busy", 64'(busy), 64'(0));
      chk("stop_nout", 64'(nout), 64'(0));
      chk("stop_tick", 64'(full_tick), 64'(0));
      nin = '0;
      nin_prev = '0;
      done = '0;
      r = 0;
      @(negedge clk);
    end
  endtask

  task automatic readout();
    int k = 0;
    pulse(1'b0, 1'b1, 1'b0);
    for (int c = 0; c < 300 && k < N; c++) begin
      chk("rd_valid", 64'(rd_valid), 64'(1));
      chk("rd_data", 64'(rd_data), 64'(phi_m[k]));
      chk("rd_last", 64'(rd_last), 64'(k == N - 1));
      rd_ready = c >= 3 && $urandom_range(0, 1) == 1;
      @(negedge clk);
      if (rd_ready) k++;
    end
    rd_ready = 1'b0;
    chk("rd_words", 64'(k), 64'(N));
    chk("rd_valid_end", 64'(rd_valid), 64'(0));
    chk("rd_busy_end", 64'(busy), 64'(0));
    chk("rd_phi_live", 64'(phi_flat), 64'(pack()));
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_nout", 64'(nout), 64'(0));
    chk("rst_phi", 64'(phi_flat), 64'(0));
    chk("rst_ld_ready", 64'(ld_ready), 64'(0));
    chk("rst_rd_valid", 64'(rd_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    // simultaneous commands: load wins; first bit sent lands in neuron N-1
    load(N'(1), 2, 1'b1);
    chk("load_pattern", 64'(phi_flat), 64'(60'h8) << 56);
    n_tick = 0; n_hi0 = 0; n_hi14 = 0;
    pulse(1'b0, 1'b0, 1'b1);
    run_model(160, 0, -1, 0);
    chk("free_ticks", 64'(n_tick), 64'(10));
    chk("free_hi0", 64'(n_hi0), 64'(80));
    chk("free_hi14", 64'(n_hi14), 64'(79));
    chk("free_phi", 64'(phi_flat), 64'(60'h8) << 56);
    run_model(40, 0, 5, 0);
    pulse(1'b0, 1'b0, 1'b1);
    run_model(64, 1, -1, 0);
    chk("nudge_phi0", 64'(phi_flat[PW-1:0]), 64'(3));
    run_model(32, 0, 15, 0);
    readout();
    for (int t = 0; t < 4; t++) begin
      load(N'($urandom), -1, 1'b0);
      pulse(1'b0, 1'b0, 1'b1);
      run_model(400, 2, int'($urandom_range(0, PMAX)), int'($urandom_range(16, 80)));
      readout();
    end
    // asynchronous reset in the middle of a load
    pulse(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      ld_valid = 1'b1;
      ld_data = 1'b1;
      @(negedge clk);
    end
    ld_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midload_phi", 64'(phi_flat), 64'(0));
    chk("midload_ld_ready", 64'(ld_ready), 64'(0));
    chk("midload_busy", 64'(busy), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    // asynchronous reset in the middle of a run
    load(N'($urandom), 0, 1'b0);
    pulse(1'b0, 1'b0, 1'b1);
    run_model(37, 2, -1, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrun_nout", 64'(nout), 64'(0));
    chk("midrun_phi", 64'(phi_flat), 64'(0));
    chk("midrun_ld_ready", 64'(ld_ready), 64'(0));
    chk("midrun_rd_valid", 64'(rd_valid), 64'(0));
    chk("midrun_busy", 64'(busy), 64'(0));
    chk("midrun_tick", 64'(full_tick), 64'(0));
    nin = '0;
    @(negedge clk);
    rst_n = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
